multdiv_ctrl: RTL and testbench



---
 rtl/md_pkg.sv | 22 ++
 rtl/md_watchdog.sv | 27 ++
 rtl/multdiv_ctrl.sv | 141 ++++++++++++++
 tb/tb_multdiv_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide issue/writeback controller.
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } md_state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_t;

    localparam logic [31:0] MD_ST_MULT    = 32'd1;
    localparam logic [31:0] MD_ST_DIV     = 32'd2;
    localparam logic [31:0] MD_ST_TIMEOUT = 32'd3;

    localparam int MD_STATUS_REG = 30;

endpackage

// File: rtl/md_watchdog.sv
// WAIT-phase cycle counter; expired flags the cycle whose edge would bring the count to TIMEOUT.
module md_watchdog #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end
    end

    // Firing one count early lets the FSM leave WAIT after exactly TIMEOUT cycles.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Issues mult/div requests to the multi-cycle units, stalls execute, and returns one writeback.
module multdiv_ctrl
    import md_pkg::*;
#(
    parameter int TIMEOUT    = 40,
    parameter int STATUS_REG = MD_STATUS_REG
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_mult,
    input  logic        ctrl_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  dest_reg,
    output logic        stall,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        mult_enable,
    output logic        div_enable,
    input  logic [31:0] mult_result,
    input  logic [31:0] div_result,
    input  logic        mult_ready,
    input  logic        div_ready,
    input  logic        mult_exception,
    input  logic        div_exception,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        wb_exc
);

    localparam logic [4:0] STATUS_IDX = 5'(STATUS_REG);

    md_state_t   state, state_next;
    md_op_t      op_q;
    logic [4:0]  dest_q;
    logic        first_wait;
    logic        expired;
    logic        sel_ready, sel_exc, ready_seen;
    logic [31:0] sel_result;
    logic        req, div_by_zero;

    assign req         = ctrl_mult || ctrl_div;
    assign div_by_zero = !ctrl_mult && ctrl_div && (operand_b == 32'd0);

    assign sel_ready  = (op_q == OP_MULT) ? mult_ready     : div_ready;
    assign sel_exc    = (op_q == OP_MULT) ? mult_exception : div_exception;
    assign sel_result = (op_q == OP_MULT) ? mult_result    : div_result;
    // A ready seen in the first WAIT cycle may be left over from the previous run.
    assign ready_seen = sel_ready && !first_wait;

    md_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        stall       = (state != ST_IDLE);
        mult_enable = 1'b0;
        div_enable  = 1'b0;
        wb_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) state_next = div_by_zero ? ST_WB : ST_ISSUE;
            end
            ST_ISSUE: begin
                mult_enable = (op_q == OP_MULT);
                div_enable  = (op_q == OP_DIV);
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_seen || expired) state_next = ST_WB;
            end
            ST_WB: begin
                wb_valid = 1'b1;
                if (wb_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            md_a       <= '0;
            md_b       <= '0;
            dest_q     <= '0;
            op_q       <= OP_MULT;
            first_wait <= 1'b0;
            wb_reg     <= '0;
            wb_data    <= '0;
            wb_exc     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        md_a   <= operand_a;
                        md_b   <= operand_b;
                        dest_q <= dest_reg;
                        op_q   <= ctrl_mult ? OP_MULT : OP_DIV;
                        if (div_by_zero) begin
                            wb_reg  <= STATUS_IDX;
                            wb_data <= MD_ST_DIV;
                            wb_exc  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: first_wait <= 1'b1;
                ST_WAIT: begin
                    first_wait <= 1'b0;
                    if (ready_seen) begin
                        if (sel_exc) begin
                            wb_reg  <= STATUS_IDX;
                            wb_data <= (op_q == OP_MULT) ? MD_ST_MULT : MD_ST_DIV;
                            wb_exc  <= 1'b1;
                        end else begin
                            wb_reg  <= dest_q;
                            wb_data <= sel_result;
                            wb_exc  <= 1'b0;
                        end
                    end else if (expired) begin
                        wb_reg  <= STATUS_IDX;
                        wb_data <= MD_ST_TIMEOUT;
                        wb_exc  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench: bench-side unit models plus a latency/value reference derived from the operation rules.
module tb_multdiv_ctrl;

    localparam int TIMEOUT = 40;
    localparam int NEVER   = 100000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_mult, ctrl_div;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  dest_reg;
    logic        stall;
    logic [31:0] md_a, md_b;
    logic        mult_enable, div_enable;
    logic [31:0] mult_result, div_result;
    logic        mult_ready, div_ready;
    logic        mult_exception, div_exception;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_exc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT), .STATUS_REG(30)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .ctrl_div       (ctrl_div),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .dest_reg       (dest_reg),
        .stall          (stall),
        .md_a           (md_a),
        .md_b           (md_b),
        .mult_enable    (mult_enable),
        .div_enable     (div_enable),
        .mult_result    (mult_result),
        .div_result     (div_result),
        .mult_ready     (mult_ready),
        .div_ready      (div_ready),
        .mult_exception (mult_exception),
        .div_exception  (div_exception),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_reg         (wb_reg),
        .wb_data        (wb_data),
        .wb_exc         (wb_exc)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_units();
        mult_ready = 1'b0; div_ready = 1'b0;
        mult_exception = 1'b0; div_exception = 1'b0;
        mult_result = $urandom; div_result = $urandom;
    endtask

    // Drive the selected unit for cycle c (relative to acceptance) and noise on the other unit.
    task automatic drive_units(input bit is_mult, input int c, input int r_start,
                               input bit unit_exc, input logic [31:0] result);
        bit rdy;
        rdy = (c >= r_start);
        if (is_mult) begin
            mult_ready = rdy; mult_exception = rdy && unit_exc;
            mult_result = rdy ? result : $urandom;
            div_ready = 1'($urandom); div_exception = 1'($urandom); div_result = $urandom;
        end else begin
            div_ready = rdy; div_exception = rdy && unit_exc;
            div_result = rdy ? result : $urandom;
            mult_ready = 1'($urandom); mult_exception = 1'($urandom); mult_result = $urandom;
        end
    endtask

    // One full request; entered and left on a negedge with the controller idle.
    task automatic run_op(input string name, input bit is_mult, input bit both,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] dest,
                          input int r_start, input bit unit_exc, input int hold);
        bit          dz;
        int          eff, exp_wb;
        logic [4:0]  e_reg;
        logic [31:0] e_data, result;
        logic        e_exc;
        logic [63:0] prod;

        prod   = 64'(a) * 64'(b);
        dz     = !is_mult && (b == 0);
        result = is_mult ? prod[31:0] : (dz ? 32'd0 : a / b);
        eff    = (r_start < 3) ? 3 : r_start;
        if (dz) begin
            exp_wb = 1; e_reg = 5'd30; e_data = 32'd2; e_exc = 1'b1;
        end else if (eff <= 1 + TIMEOUT) begin
            exp_wb = eff + 1;
            if (unit_exc) begin
                e_reg = 5'd30; e_data = is_mult ? 32'd1 : 32'd2; e_exc = 1'b1;
            end else begin
                e_reg = dest; e_data = result; e_exc = 1'b0;
            end
        end else begin
            exp_wb = 2 + TIMEOUT; e_reg = 5'd30; e_data = 32'd3; e_exc = 1'b1;
        end

        ctrl_mult = is_mult;
        ctrl_div  = !is_mult || both;
        operand_a = a; operand_b = b; dest_reg = dest;
        wb_ready  = (hold == 0);
        drive_units(is_mult, 0, r_start, unit_exc, result);

        for (int c = 1; c <= exp_wb; c++) begin
            tick();
            if (c == 1) begin
                ctrl_mult = 1'b0; ctrl_div = 1'b0;
            end else begin
                ctrl_mult = 1'($urandom); ctrl_div = 1'($urandom);
            end
            operand_a = $urandom; operand_b = $urandom; dest_reg = 5'($urandom);
            drive_units(is_mult, c, r_start, unit_exc, result);
            check({name, ".stall"}, 32'(stall), 32'd1);
            check({name, ".mult_en"}, 32'(mult_enable), 32'(c == 1 && is_mult));
            check({name, ".div_en"}, 32'(div_enable), 32'(c == 1 && !is_mult && !dz));
            if (!dz) begin
                check({name, ".md_a"}, md_a, a);
                check({name, ".md_b"}, md_b, b);
            end
            check({name, ".wb_valid"}, 32'(wb_valid), 32'(c == exp_wb));
        end
        check({name, ".wb_reg"}, 32'(wb_reg), 32'(e_reg));
        check({name, ".wb_data"}, wb_data, e_data);
        check({name, ".wb_exc"}, 32'(wb_exc), 32'(e_exc));

        for (int h = 0; h < hold; h++) begin
            tick();
            check({name, ".hold_valid"}, 32'(wb_valid), 32'd1);
            check({name, ".hold_stall"}, 32'(stall), 32'd1);
            check({name, ".hold_reg"}, 32'(wb_reg), 32'(e_reg));
            check({name, ".hold_data"}, wb_data, e_data);
            check({name, ".hold_exc"}, 32'(wb_exc), 32'(e_exc));
        end
        wb_ready  = 1'b1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        tick();
        wb_ready = 1'b0;
        idle_units();
        check({name, ".post_stall"}, 32'(stall), 32'd0);
        check({name, ".post_valid"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, ".stall"}, 32'(stall), 32'd0);
        check({name, ".mult_en"}, 32'(mult_enable), 32'd0);
        check({name, ".div_en"}, 32'(div_enable), 32'd0);
        check({name, ".wb_valid"}, 32'(wb_valid), 32'd0);
        check({name, ".wb_exc"}, 32'(wb_exc), 32'd0);
        check({name, ".wb_reg"}, 32'(wb_reg), 32'd0);
        check({name, ".wb_data"}, wb_data, 32'd0);
        check({name, ".md_a"}, md_a, 32'd0);
        check({name, ".md_b"}, md_b, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rm;

        reset = 1'b1;
        ctrl_mult = 1'b0; ctrl_div = 1'b0;
        operand_a = '0; operand_b = '0; dest_reg = '0; wb_ready = 1'b0;
        idle_units();
        @(negedge clock);
        tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        run_op("mul7x6", 1'b1, 1'b0, 32'd7, 32'd6, 5'd5, 33, 1'b0, 0);
        run_op("div100by0", 1'b0, 1'b0, 32'd100, 32'd0, 5'd3, NEVER, 1'b0, 0);
        run_op("mul_exc", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd3, 5'd9, 10, 1'b1, 0);
        run_op("div_exc", 1'b0, 1'b0, 32'd50, 32'd7, 5'd11, 6, 1'b1, 0);
        run_op("stale_rdy", 1'b1, 1'b0, 32'd12, 32'd13, 5'd1, 0, 1'b0, 0);
        run_op("both_req", 1'b1, 1'b1, 32'd5, 32'd0, 5'd4, 8, 1'b0, 0);
        run_op("edge_rdy", 1'b0, 1'b0, 32'd1000, 32'd9, 5'd7, 1 + TIMEOUT, 1'b0, 0);
        run_op("timeout", 1'b1, 1'b0, 32'd3, 32'd4, 5'd2, NEVER, 1'b0, 5);

        // Reset in the middle of WAIT, then a late ready must not resurrect the op.
        ctrl_mult = 1'b1; operand_a = 32'd21; operand_b = 32'd2; dest_reg = 5'd6;
        tick();
        ctrl_mult = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("midwait.stall", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("midreset");
        mult_ready = 1'b1; mult_result = 32'd42;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("late_rdy.stall", 32'(stall), 32'd0);
            check("late_rdy.valid", 32'(wb_valid), 32'd0);
        end
        idle_units();
        run_op("div9by3", 1'b0, 1'b0, 32'd9, 32'd3, 5'd8, 5, 1'b0, 0);

        for (int n = 0; n < 20; n++) begin
            rm = 1'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op($sformatf("rand%0d", n), rm, 1'($urandom), ra, rb, 5'($urandom),
                   int'($urandom_range(0, 2 + TIMEOUT)), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
